// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch (r0) / load-store (r1) memory sequencer, 3 cycles per access with mem_ready high.
// Requesters hold req until ack; mem_ready low stretches ACCESS. MEM_ARBITER_TIMEOUT_EN bounds ACCESS to WAIT_MAX cycles.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              mem_arbiter_clock,
    input  logic              mem_arbiter_reset_n,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_rr_last, w_rr_last_nxt;
    logic              r_gnt, w_gnt_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_r0_ack, w_r0_ack_nxt;
    logic              r_r1_ack, w_r1_ack_nxt;
    logic              w_pick;
    logic              w_timeout;

    if (WAIT_MAX < 1) begin : g_wait_max_check
        $error("mem_arbiter: WAIT_MAX must be at least 1");
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              r_err, w_err_nxt;

    // Last stall cycle before the count would hit WAIT_MAX; mem_ready still wins on that cycle.
    assign w_timeout = (r_wait == WAIT_LAST);

    always_comb begin
        w_wait_nxt = r_wait;
        w_err_nxt  = 1'b0;
        if (r_state == S_IDLE) begin
            w_wait_nxt = '0;
        end else if (r_state == S_ACCESS && !mem_ready) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
            w_err_nxt  = w_timeout;
        end
    end

    always_ff @(posedge mem_arbiter_clock or negedge mem_arbiter_reset_n) begin
        if (!mem_arbiter_reset_n) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= w_wait_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // On a tie the requester that did not win last time is picked.
    assign w_pick = (r0_req && r1_req) ? ~r_rr_last : ~r0_req;

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_last_nxt   = r_rr_last;
        w_gnt_nxt       = r_gnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_r0_ack_nxt    = 1'b0;
        w_r1_ack_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    w_state_nxt     = S_ACCESS;
                    w_mem_req_nxt   = 1'b1;
                    w_gnt_nxt       = w_pick;
                    w_rr_last_nxt   = w_pick;
                    w_mem_we_nxt    = w_pick ? r1_we    : r0_we;
                    w_mem_addr_nxt  = w_pick ? r1_addr  : r0_addr;
                    w_mem_wdata_nxt = w_pick ? r1_wdata : r0_wdata;
                end
            end
            S_ACCESS: begin
                if (mem_ready || w_timeout) begin
                    w_state_nxt   = S_DONE;
                    w_mem_req_nxt = 1'b0;
                    w_r0_ack_nxt  = ~r_gnt;
                    w_r1_ack_nxt  = r_gnt;
                    if (mem_ready && !r_mem_we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_arbiter_clock or negedge mem_arbiter_reset_n) begin
        if (!mem_arbiter_reset_n) begin
            r_state     <= S_IDLE;
            r_rr_last   <= 1'b1;
            r_gnt       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_r0_ack    <= 1'b0;
            r_r1_ack    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_gnt       <= w_gnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_r0_ack    <= w_r0_ack_nxt;
            r_r1_ack    <= w_r1_ack_nxt;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign r0_ack    = r_r0_ack;
    assign r1_ack    = r_r1_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences, then randomized traffic against a transaction model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req, r1_req, r0_we, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_ack, r1_ack, busy, err;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata;
    logic          use_mem = 1'b0;
    logic [DW-1:0] tbl_rdata;
    logic [DW-1:0] tb_mem [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(15)) dut (
        .mem_arbiter_clock  (clk),
        .mem_arbiter_reset_n(rst_n),
        .r0_req   (r0_req),
        .r1_req   (r1_req),
        .r0_we    (r0_we),
        .r1_we    (r1_we),
        .r0_addr  (r0_addr),
        .r1_addr  (r1_addr),
        .r0_wdata (r0_wdata),
        .r1_wdata (r1_wdata),
        .r0_ack   (r0_ack),
        .r1_ack   (r1_ack),
        .rdata    (rdata),
        .busy     (busy),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    function automatic logic [DW-1:0] mem_init(input int i);
        return DW'(i * 16'h0111) ^ 16'hA5A5;
    endfunction

    // Memory model: fixed pattern until the random phase, then it accepts writes.
    assign mem_rdata = use_mem ? tb_mem[mem_addr[3:0]] : tbl_rdata;
    always @(posedge clk) begin
        if (!use_mem) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= mem_init(i);
        end else if (mem_req && mem_we && mem_ready) begin
            tb_mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset acks", 32'({r1_ack, r0_ack}), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [15:0] a0, d0, a1, d1, mrd;
        logic        win, ewe;
        logic [15:0] eaddr, ewd, erd;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        int          order[$];
        int          first_ack;
        logic        saw_ack;
        logic        rq_req[2], rq_we[2];
        logic [15:0] rq_addr[2], rq_wd[2];
        logic [15:0] ref_mem[16];
        logic        prev_req[2];
        logic        prev_ready, in_flight, next_if, exp_ack, exp_grant;
        logic        win, cur_win, model_last, ack_flag;
        logic [15:0] model_rdata;
        int          free_from, low_streak;

        idle_inputs();
        mem_ready = 1'b0;
        tbl_rdata = '0;

        // r0,r1,we0,we1, a0,d0, a1,d1, mem_rdata, winner, exp we/addr/wdata/rdata
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0020, 16'h1234, 16'hDEAD, 1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'hAAAA, 16'h0031, 16'h5555, 16'h5A5A, 1'b0, 1'b0, 16'h0030, 16'hAAAA, 16'h5A5A};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'hC3C3, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hC3C3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1111, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h1111, 16'hFFFF, 16'hC3C3};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h2222, 16'h0001, 16'h3333, 16'h0002, 16'h6666, 1'b0, 1'b1, 16'h2222, 16'h0001, 16'hC3C3};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h8001, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h8001};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r0_req = tbl[i].r0; r1_req = tbl[i].r1; r0_we = tbl[i].we0; r1_we = tbl[i].we1;
            r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0; r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
            tbl_rdata = tbl[i].mrd;
            mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d mem_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("tbl%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].eaddr));
            chk($sformatf("tbl%0d mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
            chk($sformatf("tbl%0d mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].ewd));
            chk($sformatf("tbl%0d busy", i), 32'(busy), 32'd1);
            chk($sformatf("tbl%0d early ack", i), 32'({r1_ack, r0_ack}), 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d ack", i), 32'({r1_ack, r0_ack}), tbl[i].win ? 32'd2 : 32'd1);
            chk($sformatf("tbl%0d mem_req drop", i), 32'(mem_req), 32'd0);
            chk($sformatf("tbl%0d rdata", i), 32'(rdata), 32'(tbl[i].erd));
            r0_req = 1'b0; r1_req = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d idle busy", i), 32'(busy), 32'd0);
            chk($sformatf("tbl%0d idle ack", i), 32'({r1_ack, r0_ack}), 32'd0);
        end

        // Simultaneous requests straight after reset: r0 wins, the r1 write leaves rdata alone.
        do_reset();
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0010;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 16'h0020; r1_wdata = 16'h1234;
        mem_ready = 1'b1; tbl_rdata = 16'h7777;
        @(negedge clk);
        chk("tie first addr", 32'(mem_addr), 32'h0010);
        chk("tie first we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("tie first ack", 32'({r1_ack, r0_ack}), 32'd1);
        chk("tie first rdata", 32'(rdata), 32'h7777);
        r0_req = 1'b0; tbl_rdata = 16'h9999;
        @(negedge clk);
        chk("tie gap busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("tie second mem_req", 32'(mem_req), 32'd1);
        chk("tie second addr", 32'(mem_addr), 32'h0020);
        chk("tie second we", 32'(mem_we), 32'd1);
        chk("tie second wdata", 32'(mem_wdata), 32'h1234);
        @(negedge clk);
        chk("tie second ack", 32'({r1_ack, r0_ack}), 32'd2);
        chk("tie write keeps rdata", 32'(rdata), 32'h7777);
        r1_req = 1'b0;

        // Continuous contention alternates strictly.
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0100;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 16'h0200;
        for (int n = 0; n < 40 && order.size() < 6; n++) begin
            @(negedge clk);
            if (r0_ack) order.push_back(0);
            if (r1_ack) order.push_back(1);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        chk("fair count", 32'(order.size()), 32'd6);
        for (int k = 0; k < order.size(); k++) chk($sformatf("fair order%0d", k), 32'(order[k]), 32'(k % 2));

        // Four wait states: request stays presented for five ACCESS cycles.
        @(negedge clk);
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0ABC;
        mem_ready = 1'b0; tbl_rdata = 16'h2468;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("wait%0d mem_req", n), 32'(mem_req), 32'd1);
            chk($sformatf("wait%0d mem_addr", n), 32'(mem_addr), 32'h0ABC);
            chk($sformatf("wait%0d busy", n), 32'(busy), 32'd1);
            chk($sformatf("wait%0d ack", n), 32'({r1_ack, r0_ack}), 32'd0);
            if (n == 5) mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("wait ack", 32'({r1_ack, r0_ack}), 32'd1);
        chk("wait rdata", 32'(rdata), 32'h2468);
        chk("wait mem_req drop", 32'(mem_req), 32'd0);
        r0_req = 1'b0;

        // Reset in the middle of ACCESS aborts without an ack.
        @(negedge clk);
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0DDD; mem_ready = 1'b0;
        @(negedge clk);
        chk("abort pre mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort mem_req", 32'(mem_req), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        r0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("abort no ack%0d", n), 32'({r1_ack, r0_ack, busy}), 32'd0);
        end
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 16'h0EEE; mem_ready = 1'b1; tbl_rdata = 16'h4242;
        @(negedge clk);
        chk("abort r1 grant", 32'(mem_addr), 32'h0EEE);
        @(negedge clk);
        chk("abort r1 ack", 32'({r1_ack, r0_ack}), 32'd2);
        chk("abort r1 rdata", 32'(rdata), 32'h4242);
        r1_req = 1'b0;

        // mem_ready never arrives.
        @(negedge clk);
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0777; mem_ready = 1'b0; tbl_rdata = 16'h1357;
`ifdef MEM_ARBITER_TIMEOUT_EN
        first_ack = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (first_ack < 0 && r0_ack) begin
                first_ack = n;
                r0_req = 1'b0;
                chk("timeout err with ack", 32'(err), 32'd1);
            end else begin
                chk($sformatf("timeout err quiet%0d", n), 32'(err), 32'd0);
            end
        end
        chk("timeout ack cycle", 32'(first_ack), 32'd16);
        chk("timeout rdata kept", 32'(rdata), 32'h4242);
`else
        saw_ack = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (r0_ack || r1_ack) saw_ack = 1'b1;
        end
        chk("stall busy", 32'(busy), 32'd1);
        chk("stall mem_req", 32'(mem_req), 32'd1);
        chk("stall no ack", 32'(saw_ack), 32'd0);
        chk("stall err", 32'(err), 32'd0);
        mem_ready = 1'b1;
        saw_ack = 1'b0;
        for (int n = 0; n < 5 && !saw_ack; n++) begin
            @(negedge clk);
            if (r0_ack) saw_ack = 1'b1;
        end
        chk("stall release ack", 32'(saw_ack), 32'd1);
        chk("stall release rdata", 32'(rdata), 32'h1357);
        r0_req = 1'b0;
`endif

        // Randomized traffic against a transaction-level model.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
        use_mem = 1'b1;
        for (int r = 0; r < 2; r++) begin
            rq_req[r] = 1'b0; rq_we[r] = 1'b0; rq_addr[r] = '0; rq_wd[r] = '0; prev_req[r] = 1'b0;
        end
        prev_ready  = mem_ready;
        in_flight   = 1'b0;
        model_last  = 1'b1;
        cur_win     = 1'b0;
        model_rdata = '0;
        free_from   = 0;
        low_streak  = 0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            exp_ack   = in_flight && prev_ready;
            exp_grant = !in_flight && (cyc >= free_from) && (prev_req[0] || prev_req[1]);
            win = 1'b0;
            if (exp_grant) begin
                if (prev_req[0] && prev_req[1]) win = !model_last;
                else if (prev_req[1])           win = 1'b1;
            end
            next_if = exp_grant ? 1'b1 : (exp_ack ? 1'b0 : in_flight);
            chk("rnd mem_req", 32'(mem_req), 32'(next_if));
            chk("rnd busy", 32'(busy), 32'(next_if || exp_ack));
            chk("rnd acks", 32'({r1_ack, r0_ack}), 32'({exp_ack && cur_win, exp_ack && !cur_win}));
            chk("rnd err", 32'(err), 32'd0);
            if (exp_grant) begin
                cur_win    = win;
                model_last = win;
                chk("rnd grant addr", 32'(mem_addr), 32'(rq_addr[win]));
                chk("rnd grant we", 32'(mem_we), 32'(rq_we[win]));
                chk("rnd grant wdata", 32'(mem_wdata), 32'(rq_wd[win]));
            end
            ack_flag = exp_ack;
            if (exp_ack) begin
                if (rq_we[cur_win]) ref_mem[rq_addr[cur_win][3:0]] = rq_wd[cur_win];
                else                model_rdata = ref_mem[rq_addr[cur_win][3:0]];
                free_from = cyc + 2;
            end
            chk("rnd rdata", 32'(rdata), 32'(model_rdata));
            in_flight = next_if;

            for (int r = 0; r < 2; r++) begin
                if (ack_flag && (32'(cur_win) == r)) begin
                    rq_req[r] = 1'($urandom_range(1, 0));
                end else if (!rq_req[r] && $urandom_range(2, 0) == 0) begin
                    rq_req[r] = 1'b1;
                end else begin
                    continue;
                end
                rq_we[r]   = 1'($urandom_range(1, 0));
                rq_addr[r] = 16'($urandom);
                rq_wd[r]   = 16'($urandom);
            end
            if (low_streak >= 5) mem_ready = 1'b1;
            else                 mem_ready = 1'($urandom_range(1, 0));
            low_streak = mem_ready ? 0 : low_streak + 1;
            r0_req = rq_req[0]; r0_we = rq_we[0]; r0_addr = rq_addr[0]; r0_wdata = rq_wd[0];
            r1_req = rq_req[1]; r1_we = rq_we[1]; r1_addr = rq_addr[1]; r1_wdata = rq_wd[1];
            prev_req[0] = rq_req[0];
            prev_req[1] = rq_req[1];
            prev_ready  = mem_ready;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester memory access controller that sequences the shared MDR/memory data path.
- Requester 0 is instruction fetch and requester 1 is data load/store.
- The block arbitrates between them, latches address/write-data/command for the granted requester, and drives one memory transaction at a time.
- On completion it returns read data (MDR-side capture) and a one-cycle acknowledge to the winner.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width (matches MDR width)
- WAIT_MAX, 15, max wait cycles in ACCESS before timeout (used only with the optional feature)

Ports:
- mem_arbiter_clock  input  1  single clock, rising edge
- mem_arbiter_reset_n  input  1  reset, asynchronous, active-low
- r0_req / r1_req  input  1 each  request; held high until ack
- r0_we / r1_we  input  1 each  1 = write, 0 = read
- r0_addr / r1_addr  input  ADDR_W each  address
- r0_wdata / r1_wdata  input  DATA_W each  write data
- r0_ack / r1_ack  output  1 each  one-cycle completion pulse
- rdata  output  DATA_W  last read data, shared by both requesters
- busy  output  1  high while state is not IDLE
- err  output  1  timeout pulse, coincident with ack
- mem_req  output  1  memory strobe
- mem_we  output  1  write enable
- mem_addr  output  ADDR_W  address to memory
- mem_wdata  output  DATA_W  data to memory
- mem_rdata  input  DATA_W  data from memory
- mem_ready  input  1  transaction complete, sampled on rising edge

Behaviour:
- All outputs are registered.
- Reset (async, reset_n low): state=IDLE; all outputs 0; rr_last=1, so r0 wins the first tie. Asserting reset mid-transaction drops mem_req immediately and discards the transaction; no ack is issued.
- State machine: IDLE, ACCESS, DONE.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the requester that is not rr_last.
  - On grant at edge N: latch we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_req=1, record the grant index, update rr_last, go to ACCESS.
- ACCESS:
  - mem_req stays 1; mem_addr/mem_we/mem_wdata stay stable.
  - Requester inputs are ignored.
  - When mem_ready is sampled 1: mem_req goes to 0; if the transaction is a read, rdata <= mem_rdata; go to DONE.
- DONE: ack of the granted requester is 1 for exactly this cycle, then go to IDLE.
- Requester protocol: deassert req on the edge where ack is sampled high. A req still high in IDLE after DONE is treated as a new request.
- Latency with mem_ready tied high: req sampled at edge 0 → mem_req high in cycle 0–1 → ack high in the cycle after edge 1. Total 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles.
- rdata holds its value across writes and idle cycles; it updates only on read completion.
- busy = (state != IDLE).
- Requests arriving during ACCESS or DONE wait; they are never lost while req is held.
- mem_ready high outside ACCESS is ignored.
- Fairness: under continuous contention the two requesters alternate strictly.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - When the count reaches WAIT_MAX: mem_req goes to 0, rdata is unchanged, go to DONE, and assert err=1 together with the ack.
  - If mem_ready arrives in the same cycle the count reaches WAIT_MAX, the transaction completes normally with err=0.
- Undefined: no counter is built; ACCESS waits indefinitely and err is tied 0.

Test Plan:
- Single read with mem_ready tied 1: r0_req, we=0, addr=16'h0040, mem_rdata=16'hBEEF → mem_req/mem_addr=0040 for 1 cycle; r0_ack pulses 2 cycles after req sampled; rdata=BEEF; r1_ack stays 0.
- Simultaneous requests after reset: r0 read 0x0010 and r1 write 0x0020/16'h1234 both held → r0 served first, then r1 with mem_we=1 and mem_wdata=1234; rdata unchanged by the write.
- Contention fairness: both requesters re-request immediately after every ack for 6 transactions → grant order 0,1,0,1,0,1.
- Wait states: mem_ready low for 4 cycles then high, with a read → mem_req and mem_addr stable for all 5 ACCESS cycles; busy high throughout; ack 1 cycle after ready.
- Reset mid-ACCESS: assert reset_n=0 while mem_req=1 → mem_req=0 and busy=0 immediately without waiting for a clock edge; no ack; after release, a fresh r1 request is granted even while r0 is idle.
- With MEM_ARBITER_TIMEOUT_EN and WAIT_MAX=15: mem_ready held 0 → after 15 ACCESS cycles, ack and err pulse together and rdata is unchanged; without the macro, busy stays high indefinitely.
